arcade_memory_map: RTL

ARCADE_MEMORY_MAP -- requirements
Module: arcade_memory_map

---
 rtl/arcade_memory_map.sv | 137 +++++++++++++
 1 files changed

// File: rtl/arcade_memory_map.sv
// Arcade ROM/RAM/PROM map with a byte-download loader; CPU ROM reads, RAM and PROM reads have 1-cycle latency.
// No backpressure: Wait_n is low while a download session is loading, and CPU ROM reads and RAM writes are dropped then.
module arcade_memory_map #(
    parameter int          ROM0_AW       = 13,
    parameter logic [15:0] ROM0_DN_BASE  = 16'h0000,
    parameter logic [15:0] ROM0_CPU_BASE = 16'h0000,
    parameter int          ROM1_AW       = 12,
    parameter logic [15:0] ROM1_DN_BASE  = 16'h2000,
    parameter logic [15:0] ROM1_CPU_BASE = 16'h5000,
    parameter int          PROM_AW       = 11,
    parameter logic [15:0] PROM_DN_BASE  = 16'h3000,
    parameter int          RAM_AW        = 13
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic [15:0]        Addr,
    input  logic               Rd_req,
    output logic [7:0]         Rom_out,
    output logic               Rom_valid,
    input  logic               RW_n,
    input  logic [15:0]        Ram_Addr,
    input  logic [7:0]         Ram_in,
    output logic [7:0]         Ram_out,
    input  logic [PROM_AW-1:0] color_prom_addr,
    output logic [7:0]         color_prom_out,
    input  logic               dn_download,
    input  logic [15:0]        dn_addr,
    input  logic [7:0]         dn_data,
    input  logic               dn_wr,
    output logic               Wait_n,
    output logic [2:0]         Loaded,
    output logic [7:0]         Dn_sum
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOADING = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    localparam logic [16:0] ROM0_SIZE = 17'd1 << ROM0_AW;
    localparam logic [16:0] ROM1_SIZE = 17'd1 << ROM1_AW;
    localparam logic [16:0] PROM_SIZE = 17'd1 << PROM_AW;

    localparam logic [ROM0_AW:0] ROM0_FULL = {1'b1, {ROM0_AW{1'b0}}};
    localparam logic [ROM1_AW:0] ROM1_FULL = {1'b1, {ROM1_AW{1'b0}}};
    localparam logic [PROM_AW:0] PROM_FULL = {1'b1, {PROM_AW{1'b0}}};

    logic [7:0] rom0 [0:(1<<ROM0_AW)-1];
    logic [7:0] rom1 [0:(1<<ROM1_AW)-1];
    logic [7:0] prom [0:(1<<PROM_AW)-1];
    logic [7:0] ram  [0:(1<<RAM_AW)-1];

    logic [1:0]       state;
    logic             dl_q;
    logic [ROM0_AW:0] cnt0;
    logic [ROM1_AW:0] cnt1;
    logic [PROM_AW:0] cnt2;

    // 17-bit differences: an address below the base wraps into bit 16 and fails the range test.
    logic [16:0] dn_off0, dn_off1, dn_off2, cpu_off0, cpu_off1;
    logic        dn_hit0, dn_hit1, dn_hit2, cpu_hit0, cpu_hit1;
    logic        dn_rise, dn_acc, rd_acc, ram_we;

    assign dn_off0  = {1'b0, dn_addr} - {1'b0, ROM0_DN_BASE};
    assign dn_off1  = {1'b0, dn_addr} - {1'b0, ROM1_DN_BASE};
    assign dn_off2  = {1'b0, dn_addr} - {1'b0, PROM_DN_BASE};
    assign cpu_off0 = {1'b0, Addr} - {1'b0, ROM0_CPU_BASE};
    assign cpu_off1 = {1'b0, Addr} - {1'b0, ROM1_CPU_BASE};

    assign dn_hit0  = dn_off0 < ROM0_SIZE;
    assign dn_hit1  = dn_off1 < ROM1_SIZE;
    assign dn_hit2  = dn_off2 < PROM_SIZE;
    assign cpu_hit0 = cpu_off0 < ROM0_SIZE;
    assign cpu_hit1 = cpu_off1 < ROM1_SIZE;

    assign Wait_n  = (state != S_LOADING);
    assign dn_rise = dn_download && !dl_q;
    // Overlapping regions are ambiguous, so a byte must hit exactly one of them.
    assign dn_acc  = (state == S_LOADING) && dn_wr &&
                     (dn_hit0 ^ dn_hit1 ^ dn_hit2) && !(dn_hit0 && dn_hit1 && dn_hit2);
    assign rd_acc  = Rd_req && Wait_n;
    assign ram_we  = !RW_n && Wait_n;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= S_IDLE;
            dl_q   <= 1'b1;
            cnt0   <= '0;
            cnt1   <= '0;
            cnt2   <= '0;
            Loaded <= 3'b000;
            Dn_sum <= 8'h00;
        end else begin
            dl_q <= dn_download;
            if (state != S_LOADING && dn_rise) begin
                state  <= S_LOADING;
                cnt0   <= '0;
                cnt1   <= '0;
                cnt2   <= '0;
                Loaded <= 3'b000;
                Dn_sum <= 8'h00;
            end else begin
                if (state == S_LOADING && !dn_download)
                    state <= S_DONE;
                if (dn_acc) begin
                    Dn_sum <= Dn_sum + dn_data;
                    if (dn_hit0 && cnt0 != ROM0_FULL) cnt0 <= cnt0 + (ROM0_AW+1)'(1);
                    if (dn_hit1 && cnt1 != ROM1_FULL) cnt1 <= cnt1 + (ROM1_AW+1)'(1);
                    if (dn_hit2 && cnt2 != PROM_FULL) cnt2 <= cnt2 + (PROM_AW+1)'(1);
                end
                Loaded <= {cnt2 == PROM_FULL, cnt1 == ROM1_FULL, cnt0 == ROM0_FULL};
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Rom_valid <= 1'b0;
            Rom_out   <= 8'h00;
        end else begin
            Rom_valid <= rd_acc;
            if (rd_acc)
                Rom_out <= cpu_hit0 ? rom0[cpu_off0[ROM0_AW-1:0]] :
                           cpu_hit1 ? rom1[cpu_off1[ROM1_AW-1:0]] : 8'h00;
        end
    end

    // Memory arrays are never reset so contents survive an aborted session.
    always_ff @(posedge Clock) begin
        if (dn_acc && dn_hit0) rom0[dn_off0[ROM0_AW-1:0]] <= dn_data;
        if (dn_acc && dn_hit1) rom1[dn_off1[ROM1_AW-1:0]] <= dn_data;
        if (dn_acc && dn_hit2) prom[dn_off2[PROM_AW-1:0]] <= dn_data;
        if (ram_we) ram[Ram_Addr[RAM_AW-1:0]] <= Ram_in;
        Ram_out        <= ram[Ram_Addr[RAM_AW-1:0]];
        color_prom_out <= prom[color_prom_addr];
    end

endmodule
